// File: rtl/prescaled_counter.sv
// Two-stage timebase: a free-running prescaler produces a step strobe every
// PRESCALE enabled cycles, and a bounded value counter advances once per strobe.
module prescaled_counter #(
  parameter int unsigned PRESCALE = 250000,
  parameter int unsigned CNT_W    = 7,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dir,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] out,
  output logic             tick,
  output logic             tc,
  output logic             at_bound
);

  // A one-bit prescaler is kept even for PRESCALE=1 so the compare stays legal.
  localparam int unsigned      PRE_W    = (PRESCALE < 2) ? 1 : $clog2(PRESCALE);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre_cnt;
  logic             step;
  logic [CNT_W-1:0] load_clip;
  logic [CNT_W-1:0] nxt_out;
  logic             nxt_tc;

  assign step      = en && (pre_cnt == PRE_LAST);
  assign load_clip = (load_val > limit) ? limit : load_val;
  assign at_bound  = (dir && (out >= limit)) || (!dir && (out == '0));

  // Value the counter takes on a step, and whether that step hits a bound.
  always_comb begin
    nxt_out = out;
    nxt_tc  = 1'b0;
    if (dir) begin
      if (out < limit) begin
        nxt_out = out + CNT_W'(1);
      end else begin
        nxt_out = SATURATE ? limit : '0;
        nxt_tc  = 1'b1;
      end
    end else begin
      if (out > limit) begin
        // limit was lowered under a running count: snap to the new ceiling
        nxt_out = limit;
      end else if (out == '0) begin
        nxt_out = SATURATE ? '0 : limit;
        nxt_tc  = 1'b1;
      end else begin
        nxt_out = out - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pre_cnt <= '0;
      out     <= '0;
      tick    <= 1'b0;
      tc      <= 1'b0;
    end else if (clr) begin
      pre_cnt <= '0;
      out     <= '0;
      tick    <= 1'b0;
      tc      <= 1'b0;
    end else if (load) begin
      pre_cnt <= '0;
      out     <= load_clip;
      tick    <= 1'b0;
      tc      <= 1'b0;
    end else if (!en) begin
      tick    <= 1'b0;
      tc      <= 1'b0;
    end else if (step) begin
      pre_cnt <= '0;
      out     <= nxt_out;
      tick    <= 1'b1;
      tc      <= nxt_tc;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
      tick    <= 1'b0;
      tc      <= 1'b0;
    end
  end

endmodule
